// File: rtl/systolic_result_drain.sv
// Result drain for the systolic array: captures a ROWSxCOLS matrix and streams it one row per beat.
// Optional macro DRAIN_SAT_EN saturates each element to DATA_WIDTH bits before buffering.
module systolic_result_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  localparam int ACC_W     = 2 * DATA_WIDTH,
`ifdef DRAIN_SAT_EN
  localparam int OUT_W     = DATA_WIDTH,
`else
  localparam int OUT_W     = ACC_W,
`endif
  localparam int IDX_W     = $clog2(ROWS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [ACC_W*ROWS*COLS-1:0]    in_C,
  output logic                          in_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_W*COLS-1:0]         out_row,
  output logic [IDX_W-1:0]              out_idx,
  output logic                          out_last,
  output logic                          drop_err,
  output logic [7:0]                    drop_cnt
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                  state;
  logic [OUT_W*COLS-1:0]   buf_q    [ROWS];
  logic [OUT_W*COLS-1:0]   cap_rows [ROWS];
  logic                    fire;
  logic                    accept;
  logic                    drop;
  logic [IDX_W-1:0]        nxt_idx;

  function automatic logic [OUT_W-1:0] sat_elem(input logic signed [ACC_W-1:0] v);
`ifdef DRAIN_SAT_EN
    logic signed [ACC_W-1:0] max_v;
    logic signed [ACC_W-1:0] min_v;
    max_v = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    min_v = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    if (v > max_v)
      return max_v[OUT_W-1:0];
    else if (v < min_v)
      return min_v[OUT_W-1:0];
    else
      return v[OUT_W-1:0];
`else
    return v;
`endif
  endfunction

  // Saturation (if enabled) sits ahead of the buffer so capture latency is unchanged
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      cap_rows[r] = '0;
      for (int c = 0; c < COLS; c++)
        cap_rows[r][c*OUT_W +: OUT_W] = sat_elem(in_C[(r*COLS+c)*ACC_W +: ACC_W]);
    end
  end

  assign fire     = out_valid && out_ready;
  assign in_ready = (state == IDLE) || (fire && out_last);
  assign accept   = in_valid && in_ready;
  assign drop     = in_valid && !in_ready;
  assign nxt_idx  = out_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_row   <= '0;
      drop_err  <= 1'b0;
      drop_cnt  <= 8'd0;
      for (int r = 0; r < ROWS; r++)
        buf_q[r] <= '0;
    end else begin
      drop_err <= drop;
      if (drop && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;

      // A capture on the last-row fire cycle restarts the drain with no bubble
      if (accept) begin
        buf_q     <= cap_rows;
        state     <= DRAIN;
        out_valid <= 1'b1;
        out_idx   <= '0;
        out_last  <= 1'b0;
        out_row   <= cap_rows[0];
      end else if (fire) begin
        if (out_last) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          out_idx   <= '0;
        end else begin
          out_idx  <= nxt_idx;
          out_row  <= buf_q[nxt_idx];
          out_last <= (out_idx == IDX_W'(ROWS - 2));
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed testbench for systolic_result_drain (DATA_WIDTH=8, ROWS=COLS=8).
module tb_systolic_result_drain;

  localparam int DW    = 8;
  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int ACC_W = 16;
`ifdef DRAIN_SAT_EN
  localparam int OUT_W = 8;
`else
  localparam int OUT_W = 16;
`endif

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       in_valid;
  logic [ACC_W*ROWS*COLS-1:0] in_C;
  logic                       in_ready;
  logic                       out_valid;
  logic                       out_ready;
  logic [OUT_W*COLS-1:0]      out_row;
  logic [2:0]                 out_idx;
  logic                       out_last;
  logic                       drop_err;
  logic [7:0]                 drop_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  systolic_result_drain #(.DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_C(in_C), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_idx(out_idx),
    .out_last(out_last), .drop_err(drop_err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // mode 0: r*8+c, mode 1: -(r*8+c), mode 2: saturation pattern by column
  function automatic int src_val(input int mode, input int r, input int c);
    if (mode == 0) return r*8 + c;
    if (mode == 1) return -(r*8 + c);
    case (c % 4)
      0:       return 300;
      1:       return -300;
      2:       return 127;
      default: return -128;
    endcase
  endfunction

  function automatic logic [ACC_W*ROWS*COLS-1:0] build(input int mode);
    logic [ACC_W*ROWS*COLS-1:0] m;
    m = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        m[(r*COLS+c)*ACC_W +: ACC_W] = 16'(src_val(mode, r, c));
    return m;
  endfunction

  function automatic logic [OUT_W-1:0] exp_elem(input int mode, input int r, input int c);
`ifdef DRAIN_SAT_EN
    if (mode == 2) begin
      case (c % 4)
        0:       return 8'h7F;
        1:       return 8'h80;
        2:       return 8'h7F;
        default: return 8'h80;
      endcase
    end
`endif
    return OUT_W'(src_val(mode, r, c));
  endfunction

  function automatic logic [127:0] exp_row(input int mode, input int r);
    logic [127:0] v;
    v = '0;
    for (int c = 0; c < COLS; c++)
      v[c*OUT_W +: OUT_W] = exp_elem(mode, r, c);
    return v;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_beat(input string t, input int mode, input int r);
    check($sformatf("%s_valid_r%0d", t, r), 128'(out_valid), 128'(1));
    check($sformatf("%s_idx_r%0d", t, r), 128'(out_idx), 128'(r));
    check($sformatf("%s_row_r%0d", t, r), 128'(out_row), exp_row(mode, r));
    check($sformatf("%s_last_r%0d", t, r), 128'(out_last), 128'(r == 7));
  endtask

  task automatic capture(input int mode);
    in_valid = 1'b1;
    in_C     = build(mode);
    tick();
    in_valid = 1'b0;
  endtask

  // Drain rows start_r..7 with out_ready=1; next_mode>=0 chains a new matrix on the last fire
  task automatic drain(input string t, input int mode, input int start_r, input int next_mode);
    out_ready = 1'b1;
    for (int r = start_r; r < ROWS; r++) begin
      check_beat(t, mode, r);
      if (r == 7 && next_mode >= 0) begin
        in_valid = 1'b1;
        in_C     = build(next_mode);
        #1;
        check({t, "_b2b_in_ready"}, 128'(in_ready), 128'(1));
      end
      tick();
      in_valid = 1'b0;
    end
  endtask

  initial begin
    int r;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_C      = '0;
    out_ready = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_idx", 128'(out_idx), 128'(0));
    check("rst_out_last", 128'(out_last), 128'(0));
    check("rst_out_row", 128'(out_row), 128'(0));
    check("rst_drop_err", 128'(drop_err), 128'(0));
    check("rst_drop_cnt", 128'(drop_cnt), 128'(0));
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 128'(in_ready), 128'(1));

    // Plain drain, one beat per cycle
    out_ready = 1'b1;
    capture(0);
    drain("t1", 0, 0, -1);
    check("t1_idle_valid", 128'(out_valid), 128'(0));
    check("t1_idle_in_ready", 128'(in_ready), 128'(1));

    // Backpressure with out_ready 1,0,0,1,0,0...
    capture(0);
    r = 0;
    for (int k = 0; k < 100 && r < ROWS; k++) begin
      out_ready = (k % 3 == 0);
      #1;
      check_beat("t2", 0, r);
      if (out_ready) r++;
      tick();
    end
    check("t2_all_beats", 128'(r), 128'(8));
    check("t2_idle_valid", 128'(out_valid), 128'(0));

    // Back-to-back matrices
    out_ready = 1'b1;
    capture(0);
    drain("t3a", 0, 0, 1);
    check("t3_drop_err", 128'(drop_err), 128'(0));
    drain("t3b", 1, 0, -1);
    check("t3_idle_valid", 128'(out_valid), 128'(0));
    check("t3_drop_cnt", 128'(drop_cnt), 128'(0));

    // Overrun while stalled at idx 3
    out_ready = 1'b1;
    capture(0);
    tick();
    tick();
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_C      = build(1);
    #1;
    check("t4_in_ready_busy", 128'(in_ready), 128'(0));
    tick();
    in_valid = 1'b0;
    check("t4_drop_err", 128'(drop_err), 128'(1));
    check("t4_drop_cnt1", 128'(drop_cnt), 128'(1));
    check_beat("t4_hold", 0, 3);
    tick();
    check("t4_drop_err_clr", 128'(drop_err), 128'(0));
    in_valid = 1'b1;
    for (int k = 0; k < 299; k++) tick();
    in_valid = 1'b0;
    tick();
    check("t4_drop_cnt_sat", 128'(drop_cnt), 128'(255));
    check_beat("t4_hold2", 0, 3);
    drain("t4", 0, 3, -1);
    check("t4_idle_valid", 128'(out_valid), 128'(0));

    // Asynchronous reset mid-drain at idx 4
    out_ready = 1'b1;
    capture(0);
    tick();
    tick();
    tick();
    tick();
    check("t5_at_idx4", 128'(out_idx), 128'(4));
    rst_n = 1'b0;
    #1;
    check("t5_valid", 128'(out_valid), 128'(0));
    check("t5_idx", 128'(out_idx), 128'(0));
    check("t5_row", 128'(out_row), 128'(0));
    check("t5_last", 128'(out_last), 128'(0));
    check("t5_drop_cnt", 128'(drop_cnt), 128'(0));
    tick();
    rst_n = 1'b1;
    #1;
    check("t5_in_ready", 128'(in_ready), 128'(1));
    capture(1);
    drain("t5", 1, 0, -1);

    // Saturation pattern (bit-exact without the macro)
    capture(2);
    drain("t6", 2, 0, -1);
    check("t6_idle_valid", 128'(out_valid), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
